// File: rtl/regfile_mp.sv
// Multi-port register file: NR combinational read lanes, two prioritised write ports, self-timed clear sweep.
// Define REGFILE_BYPASS_EN to return same-cycle write data on matching read lanes.
module regfile_mp #(
    parameter int DW       = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int NR       = 2,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            reset,
    output logic            ready,
    input  logic [NR*AW-1:0] raddr,
    output logic [NR*DW-1:0] rdata,
    input  logic            we0,
    input  logic [AW-1:0]   waddr0,
    input  logic [DW-1:0]   wdata0,
    input  logic            we1,
    input  logic [AW-1:0]   waddr1,
    input  logic [DW-1:0]   wdata1
);

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [0:0]    state   = CLEAR;
    logic [AW-1:0] clr_idx = '0;
    logic [DW-1:0] mem [DEPTH];

    logic zero_w0;
    logic zero_w1;
    logic wr0;
    logic wr1;

    assign zero_w0 = (ZERO_REG != 0) && (waddr0 == '0);
    assign zero_w1 = (ZERO_REG != 0) && (waddr1 == '0);

    // Port 0 yields only to a port-1 write that actually targets the same entry.
    assign wr1 = we1 && !zero_w1;
    assign wr0 = we0 && !zero_w0 && !(we1 && (waddr1 == waddr0));

    assign ready = (state == RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else if (state == CLEAR) begin
            mem[clr_idx] <= '0;
            if (clr_idx == LAST_IDX) begin
                state <= RUN;
            end else begin
                clr_idx <= clr_idx + 1'b1;
            end
        end else begin
            if (wr0) begin
                mem[waddr0] <= wdata0;
            end
            if (wr1) begin
                mem[waddr1] <= wdata1;
            end
        end
    end

    for (genvar i = 0; i < NR; i++) begin : g_rd
        logic [AW-1:0] ra;
        logic [DW-1:0] lane;

        assign ra = raddr[i*AW +: AW];

        always_comb begin
            lane = mem[ra];
`ifdef REGFILE_BYPASS_EN
            if (we1 && (waddr1 == ra)) begin
                lane = wdata1;
            end else if (we0 && (waddr0 == ra)) begin
                lane = wdata0;
            end
`endif
            if ((state == CLEAR) || ((ZERO_REG != 0) && (ra == '0))) begin
                lane = '0;
            end
        end

        assign rdata[i*DW +: DW] = lane;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: clear sweep, reset restart, writes, collisions, zero entry, bypass.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              ready;
    logic [NR*AW-1:0]  raddr = '0;
    logic [NR*DW-1:0]  rdata;
    logic              we0 = 1'b0;
    logic [AW-1:0]     waddr0 = '0;
    logic [DW-1:0]     wdata0 = '0;
    logic              we1 = 1'b0;
    logic [AW-1:0]     waddr1 = '0;
    logic [DW-1:0]     wdata1 = '0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] ev;
    logic          er;
    logic [DW-1:0] mdl [DEPTH];

    regfile_mp #(
        .DW(DW), .DEPTH(DEPTH), .AW(AW), .NR(NR), .ZERO_REG(1)
    ) dut (
        .clk(clk), .reset(reset), .ready(ready),
        .raddr(raddr), .rdata(rdata),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All tasks start and end just after a falling edge.
    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr = {a1, a0};
    endtask

    task automatic test_clear_sweep();
        pulse_reset();
        for (int k = 0; k <= DEPTH; k++) begin
            set_rd(AW'(k % DEPTH), AW'(DEPTH - 1 - (k % DEPTH)));
            if (k < DEPTH) begin
                exp_q.push_back('0);
                exp_q.push_back('0);
            end
            #1;
            er = (k == DEPTH);
            n_cmp++;
            if (ready !== er) begin
                n_bad++;
                $display("FAIL sweep_ready k=%0d: got %b want %b", k, ready, er);
            end
            if (k < DEPTH) begin
                for (int l = 0; l < NR; l++) begin
                    ev = exp_q.pop_front();
                    n_cmp++;
                    if (rdata[l*DW +: DW] !== ev) begin
                        n_bad++;
                        $display("FAIL sweep_rd k=%0d lane%0d: got %h want %h",
                                 k, l, rdata[l*DW +: DW], ev);
                    end
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mid_reset();
        pulse_reset();
        repeat (10) @(negedge clk);
        #1;
        n_cmp++;
        if (ready !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_ready_pre: got %b want 0", ready);
        end
        pulse_reset();
        for (int k = 0; k <= DEPTH; k++) begin
            we0 = 1'b0;
            if (k == 20) begin
                we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hBAD0_BAD0;
            end else if (k == DEPTH - 1) begin
                we0 = 1'b1; waddr0 = 5'd2; wdata0 = 32'h0BAD_0BAD;
            end
            #1;
            er = (k == DEPTH);
            n_cmp++;
            if (ready !== er) begin
                n_bad++;
                $display("FAIL mid_ready k=%0d: got %b want %b", k, ready, er);
            end
            @(negedge clk);
        end
        we0 = 1'b0;
        set_rd(5'd3, 5'd2);
        exp_q.push_back('0);
        exp_q.push_back('0);
        #1;
        for (int l = 0; l < NR; l++) begin
            ev = exp_q.pop_front();
            n_cmp++;
            if (rdata[l*DW +: DW] !== ev) begin
                n_bad++;
                $display("FAIL mid_dropped lane%0d: got %h want %h", l, rdata[l*DW +: DW], ev);
            end
        end
    endtask

    task automatic test_basic();
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEAD_BEEF;
        set_rd(5'd5, 5'd6);
        exp_q.push_back(32'hDEAD_BEEF);
        exp_q.push_back('0);
        @(negedge clk);
        we0 = 1'b0;
        #1;
        for (int l = 0; l < NR; l++) begin
            ev = exp_q.pop_front();
            n_cmp++;
            if (rdata[l*DW +: DW] !== ev) begin
                n_bad++;
                $display("FAIL basic lane%0d: got %h want %h", l, rdata[l*DW +: DW], ev);
            end
        end
    endtask

    task automatic test_collision();
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h1111_1111;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h2222_2222;
        exp_q.push_back(32'h2222_2222);
        exp_q.push_back(32'h2222_2222);
        @(negedge clk);
        we0 = 1'b1; waddr0 = 5'd8; wdata0 = 32'h3333_3333;
        we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h4444_4444;
        set_rd(5'd7, 5'd7);
        #1;
        for (int l = 0; l < NR; l++) begin
            ev = exp_q.pop_front();
            n_cmp++;
            if (rdata[l*DW +: DW] !== ev) begin
                n_bad++;
                $display("FAIL coll_same lane%0d: got %h want %h", l, rdata[l*DW +: DW], ev);
            end
        end
        exp_q.push_back(32'h3333_3333);
        exp_q.push_back(32'h4444_4444);
        @(negedge clk);
        we0 = 1'b0; we1 = 1'b0;
        set_rd(5'd8, 5'd9);
        #1;
        for (int l = 0; l < NR; l++) begin
            ev = exp_q.pop_front();
            n_cmp++;
            if (rdata[l*DW +: DW] !== ev) begin
                n_bad++;
                $display("FAIL coll_diff lane%0d: got %h want %h", l, rdata[l*DW +: DW], ev);
            end
        end
    endtask

    task automatic test_zero_reg();
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFF_FFFF;
        we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h0000_1234;
        exp_q.push_back('0);
        exp_q.push_back(32'h0000_1234);
        @(negedge clk);
        we0 = 1'b0; we1 = 1'b0;
        set_rd(5'd0, 5'd4);
        #1;
        for (int l = 0; l < NR; l++) begin
            ev = exp_q.pop_front();
            n_cmp++;
            if (rdata[l*DW +: DW] !== ev) begin
                n_bad++;
                $display("FAIL zero_reg lane%0d: got %h want %h", l, rdata[l*DW +: DW], ev);
            end
        end
    endtask

    task automatic test_bypass();
        we0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'hCAFE_0001;
        set_rd(5'd12, 5'd12);
        exp_q.push_back(BYP ? 32'hCAFE_0001 : 32'h0);
        exp_q.push_back(BYP ? 32'hCAFE_0001 : 32'h0);
        exp_q.push_back(32'hCAFE_0001);
        exp_q.push_back(32'hCAFE_0001);
        #1;
        for (int l = 0; l < NR; l++) begin
            ev = exp_q.pop_front();
            n_cmp++;
            if (rdata[l*DW +: DW] !== ev) begin
                n_bad++;
                $display("FAIL byp_same lane%0d: got %h want %h", l, rdata[l*DW +: DW], ev);
            end
        end
        @(negedge clk);
        we0 = 1'b0;
        #1;
        for (int l = 0; l < NR; l++) begin
            ev = exp_q.pop_front();
            n_cmp++;
            if (rdata[l*DW +: DW] !== ev) begin
                n_bad++;
                $display("FAIL byp_next lane%0d: got %h want %h", l, rdata[l*DW +: DW], ev);
            end
        end
        we0 = 1'b1; waddr0 = 5'd13; wdata0 = 32'hAAAA_0000;
        we1 = 1'b1; waddr1 = 5'd13; wdata1 = 32'hBBBB_0000;
        set_rd(5'd13, 5'd13);
        exp_q.push_back(BYP ? 32'hBBBB_0000 : 32'h0);
        exp_q.push_back(BYP ? 32'hBBBB_0000 : 32'h0);
        #1;
        for (int l = 0; l < NR; l++) begin
            ev = exp_q.pop_front();
            n_cmp++;
            if (rdata[l*DW +: DW] !== ev) begin
                n_bad++;
                $display("FAIL byp_both lane%0d: got %h want %h", l, rdata[l*DW +: DW], ev);
            end
        end
        @(negedge clk);
        we0 = 1'b1; waddr0 = 5'd14; wdata0 = 32'h7777_7777;
        we1 = 1'b1; waddr1 = 5'd0;  wdata1 = 32'hFFFF_0000;
        set_rd(5'd14, 5'd0);
        exp_q.push_back(BYP ? 32'h7777_7777 : 32'h0);
        exp_q.push_back('0);
        #1;
        for (int l = 0; l < NR; l++) begin
            ev = exp_q.pop_front();
            n_cmp++;
            if (rdata[l*DW +: DW] !== ev) begin
                n_bad++;
                $display("FAIL byp_zero lane%0d: got %h want %h", l, rdata[l*DW +: DW], ev);
            end
        end
        @(negedge clk);
        we0 = 1'b0; we1 = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            mdl[16 + i] = $urandom;
            mdl[24 + i] = $urandom;
            we0 = 1'b1; waddr0 = AW'(16 + i); wdata0 = mdl[16 + i];
            we1 = 1'b1; waddr1 = AW'(24 + i); wdata1 = mdl[24 + i];
            @(negedge clk);
        end
        we0 = 1'b0; we1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_rd(AW'(16 + i), AW'(24 + i));
            exp_q.push_back(mdl[16 + i]);
            exp_q.push_back(mdl[24 + i]);
            #1;
            for (int l = 0; l < NR; l++) begin
                ev = exp_q.pop_front();
                n_cmp++;
                if (rdata[l*DW +: DW] !== ev) begin
                    n_bad++;
                    $display("FAIL b2b i=%0d lane%0d: got %h want %h",
                             i, l, rdata[l*DW +: DW], ev);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_clears();
        set_rd(5'd5, 5'd16);
        pulse_reset();
        exp_q.push_back('0);
        exp_q.push_back('0);
        #1;
        n_cmp++;
        if (ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_ready: got %b want 0", ready);
        end
        for (int l = 0; l < NR; l++) begin
            ev = exp_q.pop_front();
            n_cmp++;
            if (rdata[l*DW +: DW] !== ev) begin
                n_bad++;
                $display("FAIL rst_gate lane%0d: got %h want %h", l, rdata[l*DW +: DW], ev);
            end
        end
        repeat (DEPTH) @(negedge clk);
        exp_q.push_back('0);
        exp_q.push_back('0);
        #1;
        n_cmp++;
        if (ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_done: got %b want 1", ready);
        end
        for (int l = 0; l < NR; l++) begin
            ev = exp_q.pop_front();
            n_cmp++;
            if (rdata[l*DW +: DW] !== ev) begin
                n_bad++;
                $display("FAIL rst_cleared lane%0d: got %h want %h", l, rdata[l*DW +: DW], ev);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_clear_sweep();
        test_mid_reset();
        @(negedge clk);
        test_basic();
        test_collision();
        test_zero_reg();
        @(negedge clk);
        test_bypass();
        test_back_to_back();
        test_reset_clears();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the pipelined CPU, replacing the fixed 32x32, two-read, one-write file in the decode stage. It adds a configurable number of combinational read ports, two prioritised write ports, and an optional hardwired-zero entry. Reset starts a self-timed clear sweep with a `ready` handshake. Write-through bypass is a compile-time option.

## Interface
- `DW`, 32, data width in bits (>=1)
- `DEPTH`, 32, number of entries (power of two, >=2)
- `AW`, 5, address width; `2**AW == DEPTH`
- `NR`, 2, number of read ports (1..8)
- `ZERO_REG`, 1, when 1 entry 0 always reads 0 and ignores writes
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  reset, synchronous, active-high
- `ready`  out  1  high when the clear sweep is done and the file accepts writes
- `raddr`  in  NR*AW  read addresses; port i is `raddr[i*AW +: AW]`
- `rdata`  out  NR*DW  read data; port i is `rdata[i*DW +: DW]`
- `we0`, `waddr0`, `wdata0`  in  1/AW/DW  write port 0
- `we1`, `waddr1`, `wdata1`  in  1/AW/DW  write port 1 (priority port)

## Operation
- State machine with two states, CLEAR and RUN. Clear index `clr_idx` is AW bits wide.
- Reset asserted at an edge: state <= CLEAR, `clr_idx` <= 0. Array contents are not touched on that edge. This applies in any state, including mid-sweep, so the sweep restarts at entry 0.
- CLEAR, with reset low, at each edge: mem[`clr_idx`] <= 0.
  - If `clr_idx` == DEPTH-1: state <= RUN.
  - Otherwise: `clr_idx` <= `clr_idx` + 1. No wrap-around occurs.
- In CLEAR:
  - `ready` = 0.
  - Both write ports are ignored. Writes are dropped, not queued.
  - Every `rdata` lane reads 0.
- In RUN:
  - `ready` = 1.
  - Port 0 writes mem[`waddr0`] <= `wdata0` when `we0` is high.
  - Port 1 writes mem[`waddr1`] <= `wdata1` when `we1` is high.
- Both ports enabled and `waddr0` == `waddr1`: port 1 wins and port 0's data is discarded. Different addresses: both entries update on the same edge.
- With ZERO_REG=1, writes to address 0 are dropped on both ports. A port-1 write to address 0 does not mask a port-0 write elsewhere.
- Reads are combinational. Lane i = mem[raddr_i], subject to:
  - lane i = 0 when ZERO_REG=1 and raddr_i == 0;
  - lane i = 0 in CLEAR;
  - the bypass rule (Configuration).
- Read ports are fully independent. Any number of lanes may read the same address.

## Timing
- Read latency: 0 cycles (combinational from `raddr`, state and array).
- Write latency: 1 edge. Without bypass, the new value is visible on `rdata` after the edge.
- Clear duration: reset high at edge E0 and low from then on gives `ready` = 1 after edge E0+DEPTH. That is DEPTH cycles of `ready` = 0 after reset release.
- Output values after any reset edge:
  - `ready` = 0;
  - all `rdata` = 0;
  - this persists until the sweep completes.
- Power-up before the first reset: state undefined. Initialise the simulation model to CLEAR with `clr_idx` = 0.
- A write presented on the same edge the state moves CLEAR->RUN is dropped (state was CLEAR at that edge).

## Configuration
- Macro `REGFILE_BYPASS_EN`.
- Defined: in RUN, a read lane whose address matches an enabled write port's address in the same cycle returns that write data (write-through).
  - If both write ports match, `wdata1` is returned.
  - No bypass when ZERO_REG=1 and the address is 0.
  - No bypass in CLEAR.
- Undefined: no bypass. Lanes always return stored contents, and same-cycle writes become visible one cycle later.

## Test plan
Defaults used below: DW=32, DEPTH=32, NR=2, ZERO_REG=1.
- **Clear sweep:** reset for 1 cycle, then low -> `ready` = 0 for exactly 32 cycles, then 1. Both lanes read 0 at addresses 0..31 throughout the sweep.
- **Reset mid-sweep:** pulse reset again at cycle 10 of the sweep -> `ready` rises exactly 32 cycles after the second pulse. A write to addr 3 during the sweep is dropped, so addr 3 reads 0.
- **Basic write/read:** in RUN, `we0`=1, `waddr0`=5, `wdata0`=0xDEADBEEF -> next cycle, lane0 reading 5 gives 0xDEADBEEF and lane1 reading 6 gives 0.
- **Write collision:**
  - same edge, `we0`/`we1` to addr 7 with 0x11111111/0x22222222 -> addr 7 reads 0x22222222;
  - to addrs 8/9 -> both stored.
- **Zero register:** write 0xFFFFFFFF to addr 0 on port 1 and 0x1234 to addr 4 on port 0 -> addr 0 reads 0, addr 4 reads 0x1234.
- **Bypass:** same cycle, write 0xCAFE0001 to addr 12 on port 0 while lane1 reads 12 (old value 0):
  - with `REGFILE_BYPASS_EN` -> lane1 = 0xCAFE0001 in that cycle;
  - without -> 0 in that cycle, 0xCAFE0001 in the next.
